// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between the pipeline and the multiply/divide unit.
// The pipeline drives the request side (master); the mdu drives the status and
// the HI/LO registers (slave).
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, flush,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, flush,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit owning the HI/LO register pair.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division; both run
// on magnitudes for WIDTH clocks and fix the signs in a final FIX cycle.
// MTHI/MTLO write HI/LO directly from rs in a single cycle.
// Optional feature macro: MDU_DIV0_EN -- detect a zero divisor, skip the
// iterations and report it on dz (HI/LO untouched). Without it dz is tied low.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient/dividend}.
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]     b_q;
  logic                 is_div_q;
  logic                 neg_q;     // product / quotient must be negated
  logic                 neg_r_q;   // remainder must be negated (dividend was negative)
  logic [CNT_W-1:0]     cnt_q;
`ifdef MDU_DIV0_EN
  logic                 dz_q;
  logic                 div0_q;
`endif

  // Operand decode for a new request: signedness, sign bits and magnitudes.
  logic                 is_signed;
  logic                 rs_neg;
  logic                 rt_neg;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     rt_mag;
  logic                 rt_zero;

  // Convert the incoming operands to magnitudes and record their signs.
  always_comb begin
    // NOTE: every always_comb output gets a value on all paths, so no latch can be inferred.
    is_signed = ~bus.op[0];
    rs_neg    = is_signed & bus.rs[WIDTH-1];
    rt_neg    = is_signed & bus.rt[WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs : bus.rs;
    rt_mag    = rt_neg ? -bus.rt : bus.rt;
    rt_zero   = (bus.rt == '0);
  end

  // One iteration step: shift-add for multiply, shift-compare-subtract for divide.
  logic [WIDTH:0] part;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] sum;

  always_comb begin
    acc_d = acc_q;
    part  = '0;
    diff  = '0;
    sum   = '0;
    if (is_div_q) begin
      // Remainder shifted left with the next dividend bit brought in.
      part = acc_q[2*WIDTH-1:WIDTH-1];
      diff = part - {1'b0, b_q};
      if (!diff[WIDTH]) begin
        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_q   ? -acc_q : acc_q;
    quo_fix  = neg_q   ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Control FSM plus datapath registers; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= '0;
`ifdef MDU_DIV0_EN
      dz_q     <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      done_q <= 1'b0;
`ifdef MDU_DIV0_EN
      dz_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // A flush in the same cycle drops the request.
          if (bus.start && !bus.flush) begin
            if (!bus.op[2]) begin
              is_div_q <= bus.op[1];
              neg_q    <= rs_neg ^ rt_neg;
              neg_r_q  <= rs_neg;
              b_q      <= bus.op[1] ? rt_mag : rs_mag;
              acc_q    <= {{WIDTH{1'b0}}, (bus.op[1] ? rs_mag : rt_mag)};
              cnt_q    <= '0;
              busy_q   <= 1'b1;
`ifdef MDU_DIV0_EN
              div0_q   <= bus.op[1] && rt_zero;
              state_q  <= (bus.op[1] && rt_zero) ? FIX : CALC;
`else
              state_q  <= CALC;
`endif
            end else if (!bus.op[1]) begin
              if (bus.op[0]) begin
                lo_q <= bus.rs;
              end else begin
                hi_q <= bus.rs;
              end
            end
          end
        end

        CALC: begin
          if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= FIX;
            end
          end
        end

        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!bus.flush) begin
            done_q <= 1'b1;
`ifdef MDU_DIV0_EN
            if (div0_q) begin
              dz_q <= 1'b1;
            end else
`endif
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MDU_DIV0_EN
  assign bus.dz   = dz_q;
`else
  assign bus.dz   = 1'b0;
  // rt_zero only matters when zero-divisor detection is built in.
  logic unused_rt_zero;
  assign unused_rt_zero = rt_zero;
`endif

endmodule
